// File: rtl/camera_pkg.sv
// Shared camera constants, FSM encoding and level clamp for the scroll controller.
// Pure declarations; no timing or flow control.
package camera_pkg;
  localparam int PHY_WIDTH     = 16;
  localparam int SCREEN_H      = 480;
  localparam int CHAR_HEIGHT   = 32;
  localparam int LEVEL_WIDTH   = 5;
  localparam int MAX_LEVEL     = 31;
  localparam int STABLE_FRAMES = 2;
  localparam int SAMPLE_W      = PHY_WIDTH + 1;
  localparam int CNT_W         = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    DECIDE = 2'd2
  } state_t;

  typedef logic [LEVEL_WIDTH-1:0] level_t;

  function automatic level_t clamp_level(input level_t lvl);
    if (int'(lvl) > MAX_LEVEL) return level_t'(MAX_LEVEL);
    return lvl;
  endfunction
endpackage

// File: rtl/camera_scroll_ctrl_if.sv
// Bundle between physics/VGA timing (master) and the scroll controller (slave).
// Carries pulses and levels only; no handshake, receiver must always accept.
interface camera_scroll_ctrl_if;
  import camera_pkg::*;
  logic                 frame_start;
  logic [PHY_WIDTH-1:0] char_abs_y;
  logic                 force_valid;
  level_t               force_level;
  level_t               camera_y;
  logic                 camera_update;
  logic                 busy;

  modport master (output frame_start, char_abs_y, force_valid, force_level,
                  input  camera_y, camera_update, busy);
  modport slave  (input  frame_start, char_abs_y, force_valid, force_level,
                  output camera_y, camera_update, busy);
endinterface

// File: rtl/level_divider.sv
// Serial repeated-subtraction divide by SCREEN_H, quotient clamped to MAX_LEVEL.
// One subtraction per cycle, done after quotient+1 cycles; start always reloads.
module level_divider
  import camera_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [SAMPLE_W-1:0] dividend,
  output logic                done,
  output level_t              quotient
);
  logic [SAMPLE_W-1:0] rem_q;
  logic                step;

  assign step = (rem_q >= SAMPLE_W'(SCREEN_H)) && (quotient < level_t'(MAX_LEVEL));
  assign done = !step;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q    <= '0;
      quotient <= '0;
    end else if (start) begin
      rem_q    <= dividend;
      quotient <= '0;
    end else if (step) begin
      rem_q    <= rem_q - SAMPLE_W'(SCREEN_H);
      quotient <= quotient + level_t'(1);
    end
  end
endmodule

// File: rtl/camera_scroll_ctrl.sv
// Derives the camera level from character Y, debounces it and commits on frame_start.
// Level ready quotient+2 cycles after frame_start; camera_y moves only on frame_start.
// No backpressure: frame_start/force_valid pulses are always accepted and retrigger.
module camera_scroll_ctrl
  import camera_pkg::*;
(
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  camera_scroll_ctrl_if.slave bus
);
  state_t              state_q, state_d;
  level_t              cand_q, force_lvl_q, camera_y_q, next_cam, force_clamped, q;
  logic [CNT_W-1:0]    stable_cnt_q, cnt_next;
  logic                commit_pending_q, force_pending_q, camera_update_q, div_done;
  logic                decide_en;
  logic [SAMPLE_W-1:0] sample;

  assign sample = SAMPLE_W'(bus.char_abs_y) + SAMPLE_W'(CHAR_HEIGHT / 2);

  level_divider u_div (
    .clk      (sys_clk),
    .rst      (sys_rst_n),
    .start    (bus.frame_start),
    .dividend (sample),
    .done     (div_done),
    .quotient (q)
  );

  always_ff @(posedge sys_clk or posedge sys_rst_n) begin
    if (sys_rst_n) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = IDLE;
      CALC:    if (div_done) state_d = DECIDE;
      DECIDE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.frame_start) state_d = CALC;
  end

  always_comb begin
    force_clamped = clamp_level(bus.force_level);
    if (bus.force_valid)       next_cam = force_clamped;
    else if (force_pending_q)  next_cam = force_lvl_q;
    else if (commit_pending_q) next_cam = cand_q;
    else                       next_cam = camera_y_q;

    if (q != cand_q)                                    cnt_next = CNT_W'(1);
    else if (stable_cnt_q >= CNT_W'(STABLE_FRAMES))     cnt_next = CNT_W'(STABLE_FRAMES);
    else                                                cnt_next = stable_cnt_q + CNT_W'(1);

    // A pending force freezes the debounce until it has been committed.
    decide_en = (state_q == DECIDE) && !bus.frame_start && !bus.force_valid && !force_pending_q;
  end

  always_ff @(posedge sys_clk or posedge sys_rst_n) begin
    if (sys_rst_n) begin
      camera_y_q       <= '0;
      camera_update_q  <= 1'b0;
      cand_q           <= '0;
      stable_cnt_q     <= '0;
      commit_pending_q <= 1'b0;
      force_pending_q  <= 1'b0;
      force_lvl_q      <= '0;
    end else begin
      camera_update_q <= 1'b0;
      if (bus.frame_start) begin
        camera_y_q       <= next_cam;
        camera_update_q  <= (next_cam != camera_y_q);
        commit_pending_q <= 1'b0;
        force_pending_q  <= 1'b0;
        if (bus.force_valid) begin
          force_lvl_q  <= force_clamped;
          stable_cnt_q <= '0;
        end
      end else if (bus.force_valid) begin
        force_lvl_q     <= force_clamped;
        force_pending_q <= 1'b1;
        stable_cnt_q    <= '0;
      end else if (decide_en) begin
        if (q == camera_y_q) begin
          stable_cnt_q     <= '0;
          commit_pending_q <= 1'b0;
        end else begin
          cand_q           <= q;
          stable_cnt_q     <= cnt_next;
          commit_pending_q <= (cnt_next >= CNT_W'(STABLE_FRAMES));
        end
      end
    end
  end

  assign bus.camera_y      = camera_y_q;
  assign bus.camera_update = camera_update_q;
  assign bus.busy          = (state_q != IDLE);
endmodule

// File: tb/tb_camera_scroll_ctrl.sv
// Directed vector table, hand corner sequences and a randomized run against a frame-level model.
module tb_camera_scroll_ctrl;
  import camera_pkg::*;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b1;
  always #5 sys_clk = ~sys_clk;

  camera_scroll_ctrl_if bus();

  camera_scroll_ctrl dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [15:0] y;
    logic        fv;
    logic [4:0]  fl;
    int          cam;
    int          upd;
    int          q;
  } vec_t;
  vec_t vq[$];

  // frame-level reference state
  int m_cam, m_fp, m_fl, m_cp, m_last, m_run;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int clampi(input int v);
    return (v > MAX_LEVEL) ? MAX_LEVEL : v;
  endfunction

  task automatic m_reset();
    m_cam = 0; m_fp = 0; m_fl = 0; m_cp = 0; m_last = 0; m_run = 0;
  endtask

  task automatic m_force(input int fl);
    m_fp = 1; m_fl = clampi(fl); m_run = 0;
  endtask

  task automatic m_frame(input logic [15:0] y, input logic fv, input int fl,
                         output int e_cam, output int e_upd, output int e_q);
    int nc;
    if (fv)        nc = clampi(fl);
    else if (m_fp) nc = m_fl;
    else if (m_cp) nc = m_last;
    else           nc = m_cam;
    e_upd = (nc != m_cam);
    m_cam = nc; m_fp = 0; m_cp = 0;
    if (fv) m_run = 0;
    e_q = clampi((int'(y) + CHAR_HEIGHT / 2) / SCREEN_H);
    if (e_q == m_cam) begin
      m_run = 0; m_cp = 0;
    end else begin
      if (m_run > 0 && e_q == m_last) m_run++;
      else begin m_last = e_q; m_run = 1; end
      m_cp = (m_run >= STABLE_FRAMES);
    end
    e_cam = m_cam;
  endtask

  task automatic do_frame(input logic [15:0] y, input logic fv, input logic [4:0] fl,
                          output int cam, output int upd, output int q,
                          output int busy_n, output int extra, output int tmo);
    @(negedge sys_clk);
    bus.frame_start = 1'b1; bus.char_abs_y = y; bus.force_valid = fv; bus.force_level = fl;
    @(negedge sys_clk);
    bus.frame_start = 1'b0; bus.force_valid = 1'b0;
    cam = int'(bus.camera_y); upd = int'(bus.camera_update);
    busy_n = 0; extra = 0; q = -1; tmo = 1;
    for (int i = 0; i < 100; i++) begin
      if (!bus.busy) begin tmo = 0; break; end
      busy_n++;
      if (dut.state_q == DECIDE) q = int'(dut.u_div.quotient);
      if (i > 0 && bus.camera_update) extra++;
      @(negedge sys_clk);
    end
  endtask

  task automatic frame_chk(input string tag, input logic [15:0] y, input logic fv,
                           input logic [4:0] fl, input int e_cam, input int e_upd, input int e_q);
    int cam, upd, q, busy_n, extra, tmo;
    do_frame(y, fv, fl, cam, upd, q, busy_n, extra, tmo);
    check($sformatf("%s_cam", tag), cam, e_cam);
    check($sformatf("%s_upd", tag), upd, e_upd);
    check($sformatf("%s_q", tag), q, e_q);
    check($sformatf("%s_busy_cycles", tag), busy_n, e_q + 2);
    check($sformatf("%s_stray_update", tag), extra, 0);
    check($sformatf("%s_timeout", tag), tmo, 0);
  endtask

  task automatic pulse_force(input logic [4:0] fl);
    @(negedge sys_clk);
    bus.force_valid = 1'b1; bus.force_level = fl;
    @(negedge sys_clk);
    bus.force_valid = 1'b0;
  endtask

  task automatic add(input logic [15:0] y, input logic fv, input logic [4:0] fl,
                     input int cam, input int upd, input int q);
    vec_t v;
    v.y = y; v.fv = fv; v.fl = fl; v.cam = cam; v.upd = upd; v.q = q;
    vq.push_back(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ec, eu, eq, prev_l, l, v;
    logic [15:0] y;
    logic fv;
    logic [4:0] fl, fl2;

    bus.frame_start = 1'b0; bus.char_abs_y = '0; bus.force_valid = 1'b0; bus.force_level = '0;

    add(16'd100, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++)
      if (i % 2 == 0) add(16'd500, 0, 0, 0, 0, 1);
      else            add(16'd100, 0, 0, 0, 0, 0);
    add(16'd500, 0, 0, 0, 0, 1);
    add(16'd500, 0, 0, 0, 0, 1);
    add(16'd500, 0, 0, 1, 1, 1);
    add(16'd464, 0, 0, 1, 0, 1);
    add(16'd463, 0, 0, 1, 0, 0);
    add(16'd463, 0, 0, 1, 0, 0);
    add(16'd463, 0, 0, 0, 1, 0);
    add(16'hFFFF, 0, 0, 0, 0, 31);
    add(16'hFFFF, 0, 0, 0, 0, 31);
    add(16'hFFFF, 0, 0, 31, 1, 31);
    add(16'hFFFF, 0, 0, 31, 0, 31);
    add(16'd100, 1, 5'd7, 7, 1, 0);
    add(16'd100, 0, 0, 7, 0, 0);
    add(16'd3000, 0, 0, 0, 1, 6);

    repeat (2) @(negedge sys_clk);
    check("reset_camera_y", bus.camera_y, 0);
    check("reset_update", bus.camera_update, 0);
    check("reset_busy", bus.busy, 0);
    sys_rst_n = 1'b0;

    foreach (vq[i])
      frame_chk($sformatf("vec%0d", i), vq[i].y, vq[i].fv, vq[i].fl, vq[i].cam, vq[i].upd, vq[i].q);

    pulse_force(5'd7);
    frame_chk("force7", 16'd100, 0, 0, 7, 1, 0);
    pulse_force(5'd31);
    frame_chk("force31", 16'd100, 0, 0, 31, 1, 0);

    @(negedge sys_clk);
    bus.frame_start = 1'b1; bus.char_abs_y = 16'hFFFF;
    @(negedge sys_clk);
    bus.frame_start = 1'b0;
    repeat (4) @(negedge sys_clk);
    check("midcalc_busy_before_reset", bus.busy, 1);
    sys_rst_n = 1'b1;
    #1;
    check("midcalc_reset_camera_y", bus.camera_y, 0);
    check("midcalc_reset_busy", bus.busy, 0);
    check("midcalc_reset_update", bus.camera_update, 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b0;

    m_reset();
    prev_l = 0;
    for (int n = 0; n < 80; n++) begin
      l = ($urandom_range(0, 1) == 1) ? prev_l : int'($urandom_range(0, 6));
      prev_l = l;
      v = l * SCREEN_H + int'($urandom_range(0, SCREEN_H - 1));
      y = (v < 16) ? 16'd0 : 16'(v - 16);
      if ($urandom_range(0, 9) == 0) y = 16'($urandom);
      fv = ($urandom_range(0, 9) == 0);
      fl = 5'($urandom);
      m_frame(y, fv, int'(fl), ec, eu, eq);
      frame_chk($sformatf("rnd%0d", n), y, fv, fl, ec, eu, eq);
      if ($urandom_range(0, 7) == 0) begin
        fl2 = 5'($urandom);
        pulse_force(fl2);
        m_force(int'(fl2));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
